// File: rtl/stepper_seq.sv
// stepper_seq: register-programmed stepper motor pattern sequencer.
// A run steps through a coil pattern table (R5..R28) every P cycles, for N
// steps or continuously, forward or reverse. Optional build macro:
//   STEPPER_IDLE_RELEASE_EN - de-energise the coils (drive 0) whenever idle.
module stepper_seq (
  input  logic         system1000,
  input  logic         system1000_rst,
  input  logic [239:0] regs,
  input  logic         start,
  input  logic         abort,
  output logic [3:0]   coils,
  output logic         step_pulse,
  output logic         busy,
  output logic         done,
  output logic [4:0]   phase_idx,
  output logic [7:0]   steps_left
);

  typedef enum logic [1:0] {S_IDLE, S_STEP, S_DWELL, S_DONE} state_t;

  state_t      state_q, state_d;
  logic [3:0]  coils_q, coils_d;
  logic        step_pulse_q, step_pulse_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic [4:0]  phase_idx_q, phase_idx_d;
  logic [7:0]  steps_left_q, steps_left_d;
  logic [15:0] dwell_q, dwell_d;
  // run parameters captured at start
  logic [15:0] per_q, per_d;
  logic [4:0]  len_q, len_d;
  logic        dir_q, dir_d;
  logic        cont_q, cont_d;

  // register bank fields (byte k lives at bits [239-8k : 232-8k])
  logic [7:0]  ctrl;
  logic [15:0] per_raw;
  logic [7:0]  n_raw;
  logic [7:0]  len_raw;
  assign ctrl    = regs[239:232];
  assign per_raw = regs[231:216];
  assign n_raw   = regs[215:208];
  assign len_raw = regs[207:200];

  logic unused_bits;
  assign unused_bits = ^{ctrl[7:3], regs[7:0]};

  // sanitised snapshot values: zero period/length act as 1, length clamps at 24
  logic [15:0] per_eff;
  logic [4:0]  len_eff;
  assign per_eff = (per_raw == 16'd0) ? 16'd1 : per_raw;
  assign len_eff = (len_raw == 8'd0) ? 5'd1 :
                   (len_raw > 8'd24) ? 5'd24 : len_raw[4:0];

  // next pattern index and its live coil entry R(5+idx)[3:0]
  logic [4:0] nxt_idx;
  logic [4:0] rk;
  logic [3:0] pat_val;
  always_comb begin
    if (dir_q)
      nxt_idx = (phase_idx_q == 5'd0) ? len_q - 5'd1 : phase_idx_q - 5'd1;
    else
      nxt_idx = (phase_idx_q >= len_q - 5'd1) ? 5'd0 : phase_idx_q + 5'd1;
    rk      = 5'd24 - nxt_idx;
    pat_val = regs[{rk, 3'b000} +: 4];
  end

  // steps remaining after the current step
  logic [7:0] sl_dec;
  assign sl_dec = cont_q ? steps_left_q : steps_left_q - 8'd1;

  // a dropped enable behaves exactly like abort while stepping or dwelling
  logic stop_run;
  assign stop_run = abort || !ctrl[0];

  // next-state and registered-output computation
  logic to_idle;
  always_comb begin
    state_d      = state_q;
    coils_d      = coils_q;
    step_pulse_d = 1'b0;
    busy_d       = busy_q;
    done_d       = 1'b0;
    phase_idx_d  = phase_idx_q;
    steps_left_d = steps_left_q;
    dwell_d      = dwell_q;
    per_d        = per_q;
    len_d        = len_q;
    dir_d        = dir_q;
    cont_d       = cont_q;
    to_idle      = 1'b0;
    case (state_q)
      S_IDLE: begin
`ifdef STEPPER_IDLE_RELEASE_EN
        coils_d = 4'd0;
`endif
        if (start && !abort && ctrl[0]) begin
          per_d        = per_eff;
          len_d        = len_eff;
          dir_d        = ctrl[1];
          cont_d       = ctrl[2];
          steps_left_d = n_raw;
          busy_d       = 1'b1;
          if (phase_idx_q >= len_eff) phase_idx_d = 5'd0;
          state_d = (n_raw == 8'd0 && !ctrl[2]) ? S_DONE : S_STEP;
        end
      end
      S_STEP: begin
        if (stop_run) to_idle = 1'b1;
        else begin
          phase_idx_d  = nxt_idx;
          coils_d      = pat_val;
          step_pulse_d = 1'b1;
          steps_left_d = sl_dec;
          if (per_q == 16'd1) begin
            state_d = (sl_dec == 8'd0 && !cont_q) ? S_DONE : S_STEP;
          end else begin
            dwell_d = per_q - 16'd2;
            state_d = S_DWELL;
          end
        end
      end
      S_DWELL: begin
        if (stop_run) to_idle = 1'b1;
        else if (dwell_q == 16'd0)
          state_d = (steps_left_q == 8'd0 && !cont_q) ? S_DONE : S_STEP;
        else
          dwell_d = dwell_q - 16'd1;
      end
      S_DONE: begin
        to_idle = 1'b1;
        done_d  = !abort;
      end
      default: to_idle = 1'b1;
    endcase
    if (to_idle) begin
      state_d = S_IDLE;
      busy_d  = 1'b0;
      dwell_d = 16'd0;
`ifdef STEPPER_IDLE_RELEASE_EN
      coils_d = 4'd0;
`endif
    end
  end

  // state and output registers, reset has priority over everything
  always_ff @(posedge system1000) begin
    if (system1000_rst) begin
      state_q      <= S_IDLE;
      coils_q      <= 4'd0;
      step_pulse_q <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      phase_idx_q  <= 5'd0;
      steps_left_q <= 8'd0;
      dwell_q      <= 16'd0;
      per_q        <= 16'd1;
      len_q        <= 5'd1;
      dir_q        <= 1'b0;
      cont_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      coils_q      <= coils_d;
      step_pulse_q <= step_pulse_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      phase_idx_q  <= phase_idx_d;
      steps_left_q <= steps_left_d;
      dwell_q      <= dwell_d;
      per_q        <= per_d;
      len_q        <= len_d;
      dir_q        <= dir_d;
      cont_q       <= cont_d;
    end
  end

  assign coils      = coils_q;
  assign step_pulse = step_pulse_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign phase_idx  = phase_idx_q;
  assign steps_left = steps_left_q;

endmodule

// File: tb/tb_stepper_seq.sv
// Bench for stepper_seq: directed vector table, hand-written corner cases and
// randomized traffic compared every cycle against a slot-based run model.
module tb_stepper_seq;
  logic         system1000 = 1'b0;
  logic         system1000_rst = 1'b1;
  logic [239:0] regs;
  logic         start = 1'b0, abort = 1'b0;
  logic [3:0]   coils;
  logic         step_pulse, busy, done;
  logic [4:0]   phase_idx;
  logic [7:0]   steps_left;

  logic [7:0]  ctrl = 8'h00, nn = 8'h00, ll = 8'h04, r29 = 8'h00;
  logic [15:0] per = 16'd1;
  logic [7:0]  pat [24];

  int checks = 0, errors = 0;
  bit cmp_en = 1'b0;

  stepper_seq dut (
    .system1000(system1000), .system1000_rst(system1000_rst), .regs(regs),
    .start(start), .abort(abort), .coils(coils), .step_pulse(step_pulse),
    .busy(busy), .done(done), .phase_idx(phase_idx), .steps_left(steps_left)
  );

  always #5 system1000 = ~system1000;

  always_comb begin
    regs = '0;
    regs[239:232] = ctrl;
    regs[231:216] = per;
    regs[215:208] = nn;
    regs[207:200] = ll;
    for (int k = 0; k < 24; k++) regs[199-8*k -: 8] = pat[k];
    regs[7:0] = r29;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: a run is a sequence of step slots every P cycles after
  // the start edge (slot k at t=1+k*P); the slot after the last step is the
  // done slot. Phase is plain modular arithmetic on the snapshot length.
  int       m_t, m_P, m_N, m_L, m_idx, m_sl;
  bit       m_act, m_dir, m_cont, m_busy, m_done, m_sp, m_ds;
  logic [3:0] m_coils;

  initial begin
    forever begin
      @(posedge system1000);
      m_sp = 0; m_done = 0;
      if (system1000_rst) begin
        m_act = 0; m_idx = 0; m_sl = 0; m_busy = 0; m_coils = 0; m_t = 0;
      end else if (!m_act) begin
        if (start && !abort && regs[232]) begin
          m_P = regs[231:216]; if (m_P == 0) m_P = 1;
          m_N = regs[215:208];
          m_L = regs[207:200]; if (m_L == 0) m_L = 1; if (m_L > 24) m_L = 24;
          m_dir = regs[233]; m_cont = regs[234];
          if (m_idx >= m_L) m_idx = 0;
          m_sl = m_N; m_busy = 1; m_act = 1; m_t = 0;
        end
      end else begin
        m_t++;
        m_ds = !m_cont && (m_t == 1 + m_N * m_P);
        if (abort || (!regs[232] && !m_ds)) begin
          m_act = 0; m_busy = 0;
`ifdef STEPPER_IDLE_RELEASE_EN
          m_coils = 0;
`endif
        end else if (m_ds) begin
          m_act = 0; m_busy = 0; m_done = 1;
`ifdef STEPPER_IDLE_RELEASE_EN
          m_coils = 0;
`endif
        end else if ((m_t - 1) % m_P == 0) begin
          m_idx   = m_dir ? (m_idx + m_L - 1) % m_L : (m_idx + 1) % m_L;
          m_coils = regs[232 - 8*(5 + m_idx) +: 4];
          m_sp    = 1;
          if (!m_cont) m_sl--;
        end
      end
    end
  end

  initial begin
    forever begin
      @(negedge system1000);
      if (cmp_en) begin
        chk("model_coils", coils, m_coils);
        chk("model_step_pulse", step_pulse, m_sp);
        chk("model_busy", busy, m_busy);
        chk("model_done", done, m_done);
        chk("model_phase_idx", phase_idx, m_idx);
        chk("model_steps_left", steps_left, m_sl);
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

  task automatic do_reset();
    start = 0; abort = 0; system1000_rst = 1;
    @(negedge system1000);
    system1000_rst = 0;
  endtask

  task automatic pulse_start();
    start = 1;
    @(negedge system1000);
    start = 0;
  endtask

  typedef struct {
    logic [7:0] c; logic [15:0] p; logic [7:0] n; logic [7:0] l;
    int pulses; int phase; int lcoils; int done_t;
  } vec_t;
  vec_t tbl [6];

  int np, lc, dt, dc, last_t, gap, exp_gap;
  bit got;

  initial begin
    for (int i = 0; i < 24; i++) pat[i] = 8'(1 << (i % 4));
    tbl[0] = '{8'h01, 16'd4, 8'd3, 8'd4, 3, 3, 8, 13};
    tbl[1] = '{8'h01, 16'd1, 8'd5, 8'd3, 5, 2, 4, 6};
    tbl[2] = '{8'h03, 16'd2, 8'd3, 8'd5, 3, 2, 4, 7};
    tbl[3] = '{8'h01, 16'd4, 8'd0, 8'd4, 0, 0, 0, 1};
    tbl[4] = '{8'h01, 16'd0, 8'd4, 8'd0, 4, 0, 1, 5};
    tbl[5] = '{8'h00, 16'd1, 8'd3, 8'd4, 0, 0, 0, -1};

    // power-up reset state
    repeat (2) @(negedge system1000);
    chk("reset_coils", coils, 0);
    chk("reset_busy", busy, 0);
    chk("reset_done", done, 0);
    chk("reset_phase", phase_idx, 0);
    chk("reset_steps_left", steps_left, 0);
    chk("reset_step_pulse", step_pulse, 0);
    cmp_en = 1;
    system1000_rst = 0;

    // vector table: one run per entry from a clean reset
    for (int i = 0; i < 6; i++) begin
      do_reset();
      ctrl = tbl[i].c; per = tbl[i].p; nn = tbl[i].n; ll = tbl[i].l;
      pulse_start();
      np = 0; lc = 0; dt = -1; dc = 0; last_t = 0; gap = 0;
      exp_gap = (tbl[i].p == 0) ? 1 : int'(tbl[i].p);
      for (int t = 1; t <= 40; t++) begin
        @(negedge system1000);
        if (step_pulse) begin
          if (np == 0) chk("vec_first_pulse_t", t, 1);
          else chk("vec_pulse_gap", t - last_t, exp_gap);
          np++; lc = coils; last_t = t;
        end
        if (done) begin dc++; if (dt < 0) dt = t; end
      end
      chk("vec_pulses", np, tbl[i].pulses);
      chk("vec_phase", phase_idx, tbl[i].phase);
      chk("vec_last_coils", lc, tbl[i].lcoils);
      chk("vec_done_t", dt, tbl[i].done_t);
      chk("vec_done_count", dc, (tbl[i].done_t < 0) ? 0 : 1);
      chk("vec_busy_after", busy, 0);
    end

    // reverse wrap with back-to-back steps
    do_reset();
    ctrl = 8'h03; per = 16'd1; nn = 8'd2; ll = 8'd4;
    pulse_start();
    @(negedge system1000);
    chk("rev_sp1", step_pulse, 1); chk("rev_phase1", phase_idx, 3); chk("rev_coils1", coils, 8);
    @(negedge system1000);
    chk("rev_sp2", step_pulse, 1); chk("rev_phase2", phase_idx, 2); chk("rev_coils2", coils, 4);
    @(negedge system1000);
    chk("rev_done", done, 1); chk("rev_busy", busy, 0);

    // zero count: done without stepping, coils untouched
    ctrl = 8'h01; nn = 8'd0;
    pulse_start();
    chk("zero_busy", busy, 1);
    @(negedge system1000);
    chk("zero_done", done, 1); chk("zero_sp", step_pulse, 0);
`ifdef STEPPER_IDLE_RELEASE_EN
    chk("zero_coils", coils, 0);
`else
    chk("zero_coils", coils, 4);
`endif

    // abort a continuous run mid-dwell
    do_reset();
    ctrl = 8'h05; per = 16'd10; nn = 8'd7; ll = 8'd4;
    pulse_start();
    np = 0; got = 0;
    for (int t = 1; t <= 40 && !got; t++) begin
      @(negedge system1000);
      if (step_pulse) np++;
      if (np == 2) got = 1;
    end
    chk("abort_second_pulse_seen", got, 1);
    repeat (5) @(negedge system1000);
    abort = 1;
    @(negedge system1000);
    abort = 0;
    chk("abort_busy", busy, 0); chk("abort_done", done, 0); chk("abort_steps_left", steps_left, 7);
`ifdef STEPPER_IDLE_RELEASE_EN
    chk("abort_coils", coils, 0);
`else
    chk("abort_coils", coils, 4);
`endif
    @(negedge system1000);
    chk("abort_no_late_done", done, 0);

    // length clamp, zero period, start ignored while busy
    do_reset();
    for (int i = 0; i < 24; i++) pat[i] = 8'(i + 1);
    ctrl = 8'h05; per = 16'd0; nn = 8'd0; ll = 8'd30;
    pulse_start();
    for (int t = 1; t <= 50; t++) begin
      start = (t == 10);
      @(negedge system1000);
      chk("clamp_pulse", step_pulse, 1);
      chk("clamp_phase", phase_idx, t % 24);
      chk("clamp_busy", busy, 1);
    end
    start = 0; abort = 1;
    @(negedge system1000);
    abort = 0;
    chk("clamp_abort_busy", busy, 0);

    // reset in the middle of a dwell, then a fresh run
    do_reset();
    for (int i = 0; i < 24; i++) pat[i] = 8'(1 << (i % 4));
    ctrl = 8'h01; per = 16'd8; nn = 8'd3; ll = 8'd4;
    pulse_start();
    repeat (3) @(negedge system1000);
    system1000_rst = 1;
    @(negedge system1000);
    chk("mrst_coils", coils, 0); chk("mrst_sp", step_pulse, 0); chk("mrst_busy", busy, 0);
    chk("mrst_done", done, 0); chk("mrst_phase", phase_idx, 0); chk("mrst_sl", steps_left, 0);
    system1000_rst = 0;
    pulse_start();
    @(negedge system1000);
    chk("mrst_rerun_sp", step_pulse, 1); chk("mrst_rerun_phase", phase_idx, 1);
    chk("mrst_rerun_coils", coils, 2); chk("mrst_rerun_sl", steps_left, 2);
    repeat (30) @(negedge system1000);

    // randomized traffic checked against the model
    for (int cyc = 0; cyc < 2500; cyc++) begin
      start = ($urandom % 8 == 0);
      abort = ($urandom % 40 == 0);
      system1000_rst = ($urandom % 400 == 0);
      if ($urandom % 70 == 0) ctrl[0] = ~ctrl[0];
      if ($urandom % 20 == 0) begin
        case ($urandom % 5)
          0: ctrl = 8'($urandom) | (($urandom % 4 != 0) ? 8'h01 : 8'h00);
          1: per  = 16'($urandom % 6);
          2: nn   = 8'($urandom % 7);
          3: ll   = 8'($urandom % 32);
          default: pat[$urandom % 24] = 8'($urandom);
        endcase
      end
      @(negedge system1000);
    end
    start = 0; abort = 0; system1000_rst = 0;
    repeat (2) @(negedge system1000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
